piso_drain: RTL and testbench



---
 rtl/piso_drain_if.sv | 38 +++
 rtl/piso_drain.sv | 131 +++++++++++++
 tb/tb_piso_drain.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/piso_drain_if.sv
// Handshake bundle between the PIPO row buffer, the drain stage and the array feeder.
// The master side drives vectors in and consumes words out; the slave side is the drain stage.
interface piso_drain_if #(
   parameter int DATA_WIDTH = 16,
   parameter int REG_NUM    = 20,
   parameter int IDX_W      = (REG_NUM > 1) ? $clog2(REG_NUM) : 1
);
   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] in [REG_NUM];
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_data;
   logic [IDX_W-1:0]      out_idx;
   logic                  out_last;

   modport master (
      output in_valid,
      output in,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_data,
      input  out_idx,
      input  out_last
   );

   modport slave (
      input  in_valid,
      input  in,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_data,
      output out_idx,
      output out_last
   );
endinterface

// File: rtl/piso_drain.sv
// Parallel-in/serial-out drain: one vector per load, words out index 0 first; first word one cycle after the load.
// Backpressure: outputs hold while out_ready is low; in_ready is low only while the shadow slot is occupied.
module piso_drain #(
   parameter int DATA_WIDTH = 16,
   parameter int REG_NUM    = 20,
   parameter int IDX_W      = (REG_NUM > 1) ? $clog2(REG_NUM) : 1
) (
   input logic          clk,
   input logic          rst,
   piso_drain_if.slave  io
);
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      DRAIN = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t                state;
   state_t                state_nxt;
   logic [IDX_W-1:0]      idx;
   logic [IDX_W-1:0]      idx_nxt;
   logic [DATA_WIDTH-1:0] act_vec [REG_NUM];
   logic [DATA_WIDTH-1:0] sh_vec  [REG_NUM];
   logic [DATA_WIDTH-1:0] word;

   logic act_valid;
   logic sh_valid;
   logic rdy;
   logic load;
   logic xfer;
   logic at_last;
   logic load_act;
   logic load_sh;
   logic promote;

   assign act_valid = (state != EMPTY);
   assign sh_valid  = (state == FULL);
   assign rdy       = !sh_valid && !rst;
   assign load      = io.in_valid && rdy;
   assign xfer      = act_valid && io.out_ready;
   assign at_last   = (idx == IDX_W'(REG_NUM - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= EMPTY;
         idx   <= '0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
      end
   end

   // A load on the edge that drains the last word refills the active slot directly, avoiding a bubble.
   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      load_act  = 1'b0;
      load_sh   = 1'b0;
      promote   = 1'b0;
      case (state)
         EMPTY: begin
            if (load) begin
               load_act  = 1'b1;
               idx_nxt   = '0;
               state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            if (xfer && at_last) begin
               idx_nxt = '0;
               if (load) begin
                  load_act = 1'b1;
               end else begin
                  state_nxt = EMPTY;
               end
            end else begin
               if (xfer) begin
                  idx_nxt = idx + 1'b1;
               end
               if (load) begin
                  load_sh   = 1'b1;
                  state_nxt = FULL;
               end
            end
         end
         FULL: begin
            if (xfer && at_last) begin
               promote   = 1'b1;
               idx_nxt   = '0;
               state_nxt = DRAIN;
            end else if (xfer) begin
               idx_nxt = idx + 1'b1;
            end
         end
         default: begin
            state_nxt = EMPTY;
            idx_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < REG_NUM; i++) begin
         if (load_act) begin
            act_vec[i] <= io.in[i];
         end else if (promote) begin
            act_vec[i] <= sh_vec[i];
         end
         if (load_sh) begin
            sh_vec[i] <= io.in[i];
         end
      end
   end

   always_comb begin
      word = '0;
      for (int i = 0; i < REG_NUM; i++) begin
         if (idx == IDX_W'(i)) begin
            word = act_vec[i];
         end
      end
   end

   always_comb begin
      io.in_ready  = rdy;
      io.out_valid = act_valid;
      io.out_data  = act_valid ? word : '0;
      io.out_idx   = idx;
      io.out_last  = act_valid && at_last;
   end
endmodule

// File: tb/tb_piso_drain.sv
// Drain-stage bench: directed scenarios and random traffic against a word-queue reference model,
// plus a short directed run on a single-word-vector instance.
module tb_piso_drain;
   localparam int DW = 16;
   localparam int RN = 20;

   logic clk;
   logic rst;
   logic rst1;

   piso_drain_if #(.DATA_WIDTH(DW), .REG_NUM(RN)) b  ();
   piso_drain_if #(.DATA_WIDTH(DW), .REG_NUM(1))  b1 ();

   piso_drain #(.DATA_WIDTH(DW), .REG_NUM(RN)) dut (
      .clk (clk),
      .rst (rst),
      .io  (b.slave)
   );

   piso_drain #(.DATA_WIDTH(DW), .REG_NUM(1)) dut1 (
      .clk (clk),
      .rst (rst1),
      .io  (b1.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int          n_assert = 0;
   int          n_fail   = 0;
   bit          accepted;
   logic [DW-1:0] vec [RN];
   // Reference: every accepted word in emission order, tagged with its index in its vector.
   logic [DW-1:0] mq [$];
   int            iq [$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_vec(input logic [DW-1:0] base);
      for (int i = 0; i < RN; i++) vec[i] = base + DW'(i);
   endtask

   task automatic rand_vec();
      for (int i = 0; i < RN; i++) vec[i] = DW'($urandom);
   endtask

   // Called just after a falling edge: drive, check, take the rising edge, update the model.
   task automatic cycle(input bit iv, input bit ord, input bit rs);
      bit            ev;
      bit            exp_rdy;
      logic [DW-1:0] ed;
      int            ei;
      b.in_valid  = iv;
      b.out_ready = ord;
      rst         = rs;
      for (int i = 0; i < RN; i++) b.in[i] = iv ? vec[i] : DW'($urandom);
      #1;
      ev      = (mq.size() > 0);
      exp_rdy = !rs && (((mq.size() + RN - 1) / RN) < 2);
      ed      = ev ? mq[0] : '0;
      ei      = ev ? iq[0] : 0;
      check("in_ready",  b.in_ready,  exp_rdy);
      check("out_valid", b.out_valid, ev);
      check("out_data",  b.out_data,  ed);
      check("out_idx",   b.out_idx,   ei);
      check("out_last",  b.out_last,  ev && (ei == RN - 1));
      accepted = 1'b0;
      @(posedge clk);
      if (rs) begin
         mq.delete();
         iq.delete();
      end else begin
         if (ev && ord) begin
            void'(mq.pop_front());
            void'(iq.pop_front());
         end
         if (iv && exp_rdy) begin
            for (int i = 0; i < RN; i++) begin
               mq.push_back(vec[i]);
               iq.push_back(i);
            end
            accepted = 1'b1;
         end
      end
      @(negedge clk);
   endtask

   bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

   initial begin
      int k;
      rst          = 1'b1;
      rst1         = 1'b1;
      b.in_valid   = 1'b0;
      b.out_ready  = 1'b1;
      b1.in_valid  = 1'b0;
      b1.out_ready = 1'b1;
      for (int i = 0; i < RN; i++) b.in[i] = '0;
      b1.in[0] = '0;
      set_vec(16'h0000);
      @(posedge clk);
      @(negedge clk);

      // Reset held, then idle after release
      repeat (3) cycle(1'b0, 1'b1, 1'b1);
      repeat (2) cycle(1'b0, 1'b1, 1'b0);

      // Single vector
      set_vec(16'h0100);
      cycle(1'b1, 1'b1, 1'b0);
      repeat (22) cycle(1'b0, 1'b1, 1'b0);

      // Back-to-back A, B, then C offered until taken
      set_vec(16'h0A00);
      cycle(1'b1, 1'b1, 1'b0);
      set_vec(16'h0B00);
      cycle(1'b1, 1'b1, 1'b0);
      set_vec(16'h0C00);
      k = 0;
      do begin
         cycle(1'b1, 1'b1, 1'b0);
         k++;
      end while (!accepted && k < 60);
      repeat (25) cycle(1'b0, 1'b1, 1'b0);

      // Backpressure with in-flight noise on the input bus
      set_vec(16'h0E00);
      cycle(1'b1, 1'b1, 1'b0);
      for (int j = 0; j < 60; j++) cycle(1'b0, pat[j % 6], 1'b0);
      repeat (5) cycle(1'b0, 1'b1, 1'b0);

      // Same-edge load on the last word
      set_vec(16'h0C80);
      cycle(1'b1, 1'b1, 1'b0);
      repeat (19) cycle(1'b0, 1'b1, 1'b0);
      set_vec(16'h0D00);
      cycle(1'b1, 1'b1, 1'b0);
      repeat (21) cycle(1'b0, 1'b1, 1'b0);

      // Reset mid-drain with shadow full, at idx 7
      set_vec(16'h0F00);
      cycle(1'b1, 1'b1, 1'b0);
      set_vec(16'h0F80);
      cycle(1'b1, 1'b1, 1'b0);
      repeat (6) cycle(1'b0, 1'b1, 1'b0);
      set_vec(16'h0FF0);
      cycle(1'b1, 1'b1, 1'b1);
      repeat (5) cycle(1'b0, 1'b1, 1'b0);

      // Random traffic
      for (int j = 0; j < 400; j++) begin
         rand_vec();
         cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), 1'b0);
      end
      repeat (45) cycle(1'b0, 1'b1, 1'b0);

      // Single-word vectors
      @(posedge clk);
      @(negedge clk);
      #1;
      check("r1_valid_rst", b1.out_valid, 1'b0);
      check("r1_ready_rst", b1.in_ready,  1'b0);
      check("r1_data_rst",  b1.out_data,  16'h0000);
      rst1 = 1'b0;
      #1;
      check("r1_ready_rel", b1.in_ready, 1'b1);
      b1.in_valid = 1'b1;
      b1.in[0]    = 16'h00AA;
      @(posedge clk);
      @(negedge clk);
      b1.in[0] = 16'h00BB;
      #1;
      check("r1_aa_valid", b1.out_valid, 1'b1);
      check("r1_aa_data",  b1.out_data,  16'h00AA);
      check("r1_aa_idx",   b1.out_idx,   1'b0);
      check("r1_aa_last",  b1.out_last,  1'b1);
      check("r1_aa_ready", b1.in_ready,  1'b1);
      @(posedge clk);
      @(negedge clk);
      b1.in_valid = 1'b0;
      b1.in[0]    = 16'h1234;
      #1;
      check("r1_bb_valid", b1.out_valid, 1'b1);
      check("r1_bb_data",  b1.out_data,  16'h00BB);
      check("r1_bb_idx",   b1.out_idx,   1'b0);
      check("r1_bb_last",  b1.out_last,  1'b1);
      @(posedge clk);
      @(negedge clk);
      #1;
      check("r1_idle_valid", b1.out_valid, 1'b0);
      check("r1_idle_data",  b1.out_data,  16'h0000);
      check("r1_idle_last",  b1.out_last,  1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
